cla_operand_gen: RTL

Hardware operand source that sits directly upstream of the parameterised carry-lookahead adder. On a start pulse it issues a programmed number of pseudo-random operand pairs `a`/`b`, restricted by a bit mask, over a valid/ready handshake. It replaces testbench-only `$random` stimulus with synthesizable stimulus for on-board adder bring-up. An optional checker compares the adder's result against an internal golden sum.

---
 rtl/cla_operand_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cla_operand_gen.sv
// Synthesizable operand source for carry-lookahead adder bring-up: masked LFSR pairs over valid/ready.
// Optional result checker enabled by defining CLA_OPGEN_CHECK_EN.
module cla_operand_gen #(
    parameter int                WIDTH2 = 8,
    parameter logic [WIDTH2-1:0] SEED_A = WIDTH2'(1),
    parameter logic [WIDTH2-1:0] SEED_B = WIDTH2'(2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH2-1:0] count,
    input  logic [WIDTH2-1:0] mask,
    output logic [WIDTH2-1:0] a,
    output logic [WIDTH2-1:0] b,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              busy,
    output logic              done,
    output logic [WIDTH2-1:0] issued
`ifdef CLA_OPGEN_CHECK_EN
    ,
    input  logic [WIDTH2:0]   result,
    output logic              mismatch,
    output logic [WIDTH2-1:0] err_count
`endif
);

    generate
        if (WIDTH2 != 4 && WIDTH2 != 8 && WIDTH2 != 16 && WIDTH2 != 32) begin : g_bad_width
            $error("cla_operand_gen: WIDTH2 must be 4, 8, 16 or 32");
        end
    endgenerate

    // Feedback taps are the polynomial exponents minus one, packed as a bit mask.
    localparam logic [31:0] TAPS_32 =
        (WIDTH2 == 4)  ? 32'h0000_000C :
        (WIDTH2 == 8)  ? 32'h0000_00B8 :
        (WIDTH2 == 16) ? 32'h0000_D008 :
                         32'h8020_0003;
    localparam logic [WIDTH2-1:0] TAP_MASK   = TAPS_32[WIDTH2-1:0];
    localparam logic [WIDTH2-1:0] ONE        = WIDTH2'(1);
    localparam logic [WIDTH2-1:0] SEED_A_EFF = (SEED_A == '0) ? ONE : SEED_A;
    localparam logic [WIDTH2-1:0] SEED_B_EFF = (SEED_B == '0) ? ONE : SEED_B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH2-1:0] lfsr_a;
    logic [WIDTH2-1:0] lfsr_b;
    logic [WIDTH2-1:0] lfsr_a_nxt;
    logic [WIDTH2-1:0] lfsr_b_nxt;
    logic [WIDTH2-1:0] count_q;
    logic [WIDTH2-1:0] mask_q;
    logic [WIDTH2-1:0] issued_nxt;
    logic              xfer;
    logic              start_acc;

    assign lfsr_a_nxt = {lfsr_a[WIDTH2-2:0], ^(lfsr_a & TAP_MASK)};
    assign lfsr_b_nxt = {lfsr_b[WIDTH2-2:0], ^(lfsr_b & TAP_MASK)};
    assign issued_nxt = issued + ONE;
    assign xfer       = op_valid && op_ready;
    assign start_acc  = (state == S_IDLE) && start;

    // Seeds are presented on the start edge itself so the first pair is ready one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lfsr_a   <= SEED_A_EFF;
            lfsr_b   <= SEED_B_EFF;
            count_q  <= '0;
            mask_q   <= '0;
            a        <= '0;
            b        <= '0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            issued   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count_q <= count;
                        mask_q  <= mask;
                        lfsr_a  <= SEED_A_EFF;
                        lfsr_b  <= SEED_B_EFF;
                        a       <= SEED_A_EFF & mask;
                        b       <= SEED_B_EFF & mask;
                        issued  <= '0;
                        if (count != '0) begin
                            state    <= S_RUN;
                            op_valid <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        lfsr_a <= lfsr_a_nxt;
                        lfsr_b <= lfsr_b_nxt;
                        a      <= lfsr_a_nxt & mask_q;
                        b      <= lfsr_b_nxt & mask_q;
                        issued <= issued_nxt;
                        if (issued_nxt == count_q) begin
                            state    <= S_DONE;
                            op_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CLA_OPGEN_CHECK_EN
    logic [WIDTH2:0] golden;
    assign golden = {1'b0, a} + {1'b0, b};

    // The adder is combinational, so its result is compared in the same cycle as the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            mismatch <= 1'b0;
            if (start_acc) begin
                err_count <= '0;
            end else if (xfer && (result != golden)) begin
                mismatch <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + ONE;
                end
            end
        end
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule
